decode_stream: RTL
==================

// Module: decode_stream
// PURPOSE
// - Sequential successor of the combinational decoder. Accepts instruction words one per
//   cycle from fetch over a valid/ready stream, pairs them into hi/lo halves, and decodes
//   opcode/rx/ry/imm into a registered output slot with its own valid/ready handshake.
// - Tracks the word address of each instruction's hi word.
// - Sits between fetch/memory and the execute stage. Field widths are parameters, not globals.
// PARAMETERS
// - WORD_SIZE      8      bits per instruction word; instruction = 2 words
// - OPCODE_BITS    5      opcode = top OPCODE_BITS of hi; must be <= WORD_SIZE
// - REGISTER_BITS  3      rx = low bits of hi; ry = top bits of lo; must be <= WORD_SIZE
// - IMM_BITS       8      imm = low IMM_BITS of lo; must be <= WORD_SIZE
// - ADDR_BITS      8      width of word-address counter
// - LEGAL_MASK     '1     2**OPCODE_BITS bits; bit n=1 means opcode n is legal
// PORTS
// - clk          in   1              rising-edge clock
// - rst          in   1              synchronous, active-high reset
// - flush        in   1              discard partial/held instruction; reload address
// - flush_addr   in   ADDR_BITS      word address loaded on flush
// - in_word      in   WORD_SIZE      instruction word from fetch
// - in_valid     in   1              in_word valid
// - in_ready     out  1              block accepts in_word this cycle
// - out_valid    out  1              decoded instruction held
// - out_ready    in   1              consumer takes decoded instruction
// - out_opcode   out  OPCODE_BITS    decoded opcode
// - out_rx       out  REGISTER_BITS  decoded rx
// - out_ry       out  REGISTER_BITS  decoded ry
// - out_imm      out  IMM_BITS       decoded immediate
// - out_addr     out  ADDR_BITS      word address of the instruction's hi word
// - out_illegal  out  1              opcode not in LEGAL_MASK (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state WAIT_HI; all out_* = 0; address counter = 0; in_ready = 0 while rst high.
// - Priority: rst > flush > normal operation.
// - Transfers: an input transfer is in_valid & in_ready; an output transfer is
//   out_valid & out_ready. Both are sampled at the rising edge.
// - FSM:
//   - WAIT_HI: in_ready = 1. On transfer, latch hi, latch cur_addr into addr_hold,
//     advance counter by 1, go to WAIT_LO.
//   - WAIT_LO: in_ready = 1. On transfer, register the decoded fields from the held hi
//     and in_word, load out_addr from addr_hold, advance counter by 1, set out_valid,
//     go to FULL.
//   - FULL: out_valid = 1; in_ready = out_ready.
//     - Output transfer with no input transfer: clear out_valid, go to WAIT_HI.
//     - Output and input transfer in the same cycle: clear out_valid, latch the new word
//       as hi, go to WAIT_LO. No bubble.
// - Latency: out_valid rises the cycle after the lo word is accepted.
// - Throughput: 1 instruction per 2 cycles.
// - Stability: all out_* fields are stable while out_valid=1 and out_ready=0.
// - Decode: opcode = hi[W-1 -: OPCODE_BITS]; rx = hi[REGISTER_BITS-1:0];
//   ry = lo[W-1 -: REGISTER_BITS]; imm = lo[IMM_BITS-1:0]. Fields may overlap; no masking.
// - Address counter wraps modulo 2**ADDR_BITS, e.g. hi at 0xFF, lo at 0x00;
//   out_addr = 0xFF.
// - Flush, any state:
//   - Next state WAIT_HI; out_valid = 0; held hi is dropped; counter = flush_addr.
//   - in_ready = 0 during the flush cycle; no transfer occurs that cycle.
//   - out_* fields other than out_valid keep their old values.
// - Reset mid-operation: same as the reset values above; any partial pair is lost.
// CONFIGURATION
// - DECODE_STREAM_ILLEGAL_OP_EN defined:
//   - out_illegal is registered with the other fields: out_illegal = ~LEGAL_MASK[opcode].
//   - An illegal instruction is still presented and handshaken normally.
// - Not defined: out_illegal is tied to 0 and LEGAL_MASK is unused.
// - The port exists in both builds.
// TESTING
// - Defaults. Reset, then words 0xA5, 0x3C with in_valid=1 and out_ready=1
//   -> out_valid=1 on the 3rd cycle after reset release; opcode=0x14, rx=5, ry=1,
//   imm=0x3C, out_addr=0x00.
// - Back-to-back stream of 8 words, out_ready=1 -> 4 instructions, out_addr 0,2,4,6,
//   one output every 2 cycles, in_ready never low.
// - Backpressure. out_ready=0 for 5 cycles while FULL -> in_ready=0, fields stable;
//   raise out_ready with in_valid=1 -> same-cycle handoff; next output 2 cycles later.
// - Flush in WAIT_LO with flush_addr=0x40 -> held hi dropped, out_valid stays 0;
//   next pair yields out_addr=0x40.
// - Wrap. flush_addr=0xFF, then 4 words -> out_addr 0xFF then 0x01.
// - With DECODE_STREAM_ILLEGAL_OP_EN and LEGAL_MASK bit 0x14 = 0, send 0xA5, 0x3C
//   -> out_illegal=1. With bit 0x14 = 1 -> 0. Without the macro -> 0 always.

Source files
------------

// File: rtl/decode_stream.sv
// Pairs hi/lo instruction words from a valid/ready stream and decodes them into a registered output slot.
// Optional feature macro: DECODE_STREAM_ILLEGAL_OP_EN registers out_illegal from LEGAL_MASK.
module decode_stream #(
    parameter int WORD_SIZE     = 8,
    parameter int OPCODE_BITS   = 5,
    parameter int REGISTER_BITS = 3,
    parameter int IMM_BITS      = 8,
    parameter int ADDR_BITS     = 8,
    parameter logic [2**OPCODE_BITS-1:0] LEGAL_MASK = '1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [ADDR_BITS-1:0]     flush_addr,
    input  logic [WORD_SIZE-1:0]     in_word,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_BITS-1:0]   out_opcode,
    output logic [REGISTER_BITS-1:0] out_rx,
    output logic [REGISTER_BITS-1:0] out_ry,
    output logic [IMM_BITS-1:0]      out_imm,
    output logic [ADDR_BITS-1:0]     out_addr,
    output logic                     out_illegal
);

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_in_ready;
    logic                     w_in_xfer;
    logic [WORD_SIZE-1:0]     r_hi;
    logic [ADDR_BITS-1:0]     r_addr;
    logic [ADDR_BITS-1:0]     r_addr_hold;
    logic [ADDR_BITS-1:0]     r_out_addr;
    logic [OPCODE_BITS-1:0]   r_opcode;
    logic [REGISTER_BITS-1:0] r_rx;
    logic [REGISTER_BITS-1:0] r_ry;
    logic [IMM_BITS-1:0]      r_imm;
    logic [OPCODE_BITS-1:0]   w_hi_opcode;

    assign w_hi_opcode = r_hi[WORD_SIZE-1 -: OPCODE_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_HI;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FULL only accepts a word when the held instruction leaves in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            WAIT_HI: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = WAIT_LO;
                end
            end
            WAIT_LO: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = FULL;
                end
            end
            FULL: begin
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_next_state = in_valid ? WAIT_LO : WAIT_HI;
                end
            end
            default: begin
                w_next_state = WAIT_HI;
            end
        endcase
        if (rst || flush) begin
            w_in_ready   = 1'b0;
            w_next_state = WAIT_HI;
        end
    end

    assign w_in_xfer = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi        <= '0;
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_out_addr  <= '0;
            r_opcode    <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_imm       <= '0;
        end else if (flush) begin
            r_addr <= flush_addr;
        end else if (w_in_xfer) begin
            r_addr <= r_addr + 1'b1;
            if (r_state == WAIT_LO) begin
                r_opcode   <= w_hi_opcode;
                r_rx       <= r_hi[REGISTER_BITS-1:0];
                r_ry       <= in_word[WORD_SIZE-1 -: REGISTER_BITS];
                r_imm      <= in_word[IMM_BITS-1:0];
                r_out_addr <= r_addr_hold;
            end else begin
                r_hi        <= in_word;
                r_addr_hold <= r_addr;
            end
        end
    end

`ifdef DECODE_STREAM_ILLEGAL_OP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (!flush && w_in_xfer && r_state == WAIT_LO) begin
            r_illegal <= ~LEGAL_MASK[w_hi_opcode];
        end
    end

    assign out_illegal = r_illegal;
`else
    assign out_illegal = 1'b0;
`endif

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_state == FULL);
    assign out_opcode = r_opcode;
    assign out_rx     = r_rx;
    assign out_ry     = r_ry;
    assign out_imm    = r_imm;
    assign out_addr   = r_out_addr;

endmodule
